// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the RAM side of the arbiter.
//
// Handshake: a requester raises reqN together with weN/addrN/wdataN and holds
// all of them stable until it sees ackN high for one cycle. After the clock
// edge that closes the ack cycle it either drops reqN or presents a new
// command. For a read, rvalidN pulses for one cycle exactly one cycle after
// ackN, with rdataN valid only in that cycle (rdataN is 0 otherwise).
interface ram_arbiter_if #(
    parameter int data_width = 16,
    parameter int addr_width = 8
);
    // port 0 (e.g. instruction fetch)
    logic                  req0;
    logic                  we0;
    logic [addr_width-1:0] addr0;
    logic [data_width-1:0] wdata0;
    logic                  ack0;
    logic                  rvalid0;
    logic [data_width-1:0] rdata0;

    // port 1 (e.g. load/store)
    logic                  req1;
    logic                  we1;
    logic [addr_width-1:0] addr1;
    logic [data_width-1:0] wdata1;
    logic                  ack1;
    logic                  rvalid1;
    logic [data_width-1:0] rdata1;

    // single-port synchronous RAM with registered read data
    logic [addr_width-1:0] mem_read_adress;
    logic [addr_width-1:0] mem_write_adress;
    logic                  mem_write;
    logic [data_width-1:0] mem_din;
    logic [data_width-1:0] mem_dout;

    // arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0,
        output ack0, rvalid0, rdata0,
        input  req1, we1, addr1, wdata1,
        output ack1, rvalid1, rdata1,
        output mem_read_adress, mem_write_adress, mem_write, mem_din,
        input  mem_dout
    );

    // requesters and RAM side
    modport master (
        output req0, we0, addr0, wdata0,
        input  ack0, rvalid0, rdata0,
        output req1, we1, addr1, wdata1,
        input  ack1, rvalid1, rdata1,
        input  mem_read_adress, mem_write_adress, mem_write, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port
// synchronous RAM. One command is captured per grant, issued to the RAM for
// one cycle, and for reads the registered RAM data is steered back to the
// requester in the following cycle.
module ram_arbiter #(
    parameter int data_width = 16,
    parameter int addr_width = 8
) (
    input  logic                clk,
    input  logic                reset,
    ram_arbiter_if.slave        bus,
    output logic [1:0]          dbg_state_o,
    output logic                dbg_prio_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  cmd_id_q, cmd_id_d;
    logic                  cmd_we_q, cmd_we_d;
    logic [addr_width-1:0] cmd_addr_q, cmd_addr_d;
    logic [data_width-1:0] cmd_wdata_q, cmd_wdata_d;
    logic                  grant1;

    // State, priority and captured command; reset abandons anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            cmd_id_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cmd_id_q    <= cmd_id_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    // Arbitration, next-state and all bus outputs.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cmd_id_d    = cmd_id_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;

        // Port 1 wins when it is alone, or when both ask and it holds priority.
        grant1 = (bus.req0 && bus.req1) ? prio_q : bus.req1;

        // Outputs idle low; the RAM address/data lines always show the
        // captured command so they are stable outside the issue cycle.
        bus.ack0             = 1'b0;
        bus.ack1             = 1'b0;
        bus.rvalid0          = 1'b0;
        bus.rvalid1          = 1'b0;
        bus.rdata0           = '0;
        bus.rdata1           = '0;
        bus.mem_write        = 1'b0;
        bus.mem_read_adress  = cmd_addr_q;
        bus.mem_write_adress = cmd_addr_q;
        bus.mem_din          = cmd_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    cmd_id_d    = grant1;
                    cmd_we_d    = grant1 ? bus.we1    : bus.we0;
                    cmd_addr_d  = grant1 ? bus.addr1  : bus.addr0;
                    cmd_wdata_d = grant1 ? bus.wdata1 : bus.wdata0;
                    prio_d      = ~grant1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // The RAM writes or captures the read address at the closing edge.
                bus.ack0      = ~cmd_id_q;
                bus.ack1      = cmd_id_q;
                bus.mem_write = cmd_we_q;
                state_d       = cmd_we_q ? IDLE : WAIT;
            end
            WAIT: begin
                // Registered RAM data is passed straight to the owning port.
                if (cmd_id_q) begin
                    bus.rvalid1 = 1'b1;
                    bus.rdata1  = bus.mem_dout;
                end else begin
                    bus.rvalid0 = 1'b1;
                    bus.rdata0  = bus.mem_dout;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Debug visibility of the sequencer state and the priority pointer.
    always_comb begin
        dbg_state_o = state_q;
        dbg_prio_o  = prio_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table-driven cycle vectors, hand-written corner
// sequences, and a randomized two-requester run against a transaction model.
module tb_ram_arbiter;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    dbg_state;
  logic          dbg_prio;

  ram_arbiter_if #(.data_width(DW), .addr_width(AW)) bus ();

  ram_arbiter #(.data_width(DW), .addr_width(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_prio_o  (dbg_prio)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Background content of never-written RAM words.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  // ---------------- RAM model: sync write, registered read ----------------
  logic [DW-1:0] ram [256];
  bit            ram_v [256];
  always @(posedge clk) begin
    if (bus.mem_write) begin
      ram[bus.mem_write_adress]   <= bus.mem_din;
      ram_v[bus.mem_write_adress] <= 1'b1;
    end
    bus.mem_dout <= ram_v[bus.mem_read_adress] ? ram[bus.mem_read_adress]
                                               : pat(bus.mem_read_adress);
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  // Move to 1 time unit after the next rising edge (start of a new cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          ack0, ack1, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
    logic          mw;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
  } vec_t;

  vec_t vq[$];

  task automatic add_row(input logic rst,
                         input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic ack0, input logic ack1, input logic rv0, input logic rv1,
                         input logic [DW-1:0] rd0, input logic [DW-1:0] rd1,
                         input logic mw, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ack0 = ack0; v.ack1 = ack1; v.rv0 = rv0; v.rv1 = rv1;
    v.rd0 = rd0; v.rd1 = rd1; v.mw = mw; v.ma = ma; v.md = md;
    vq.push_back(v);
  endtask

  // ---------------- random-run model state ----------------
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  bit            e_ack0 [8], e_ack1 [8], e_rv0 [8], e_rv1 [8], e_mw [8];
  logic [AW-1:0] e_wa [8];
  logic [DW-1:0] e_din [8];

  logic [DW-1:0] wd [6];
  int            wcnt [256];

  initial begin
    string s;
    logic          p_req [2];
    logic          p_we [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_data [2];
    logic          last_ack [2];
    int            next_dec;
    logic          m_prio;
    int            wr_total;

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      shadow[i] = pat(i[AW-1:0]);
      wcnt[i]   = 0;
    end

    // ---------- reset state ----------
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_ack1", bus.ack1, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_rdata1", bus.rdata1, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_ra", bus.mem_read_adress, 0);
    chk("rst_mem_wa", bus.mem_write_adress, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_prio", dbg_prio, 0);
    reset = 1'b0;

    // ---------- table: write/read port 0, lone port 1, write-before-read ----------
    //       rst r0 w0 a0     d0        r1 w1 a1     d1   ack0 ack1 rv0 rv1 rd0       rd1       mw ma     md
    add_row(0,  1, 1, 8'h05, 16'h1234, 0, 0, 8'h00, 0,   0,   0,   0,  0,  0,        0,        0, 8'h00, 16'h0000);
    add_row(0,  1, 1, 8'h05, 16'h1234, 0, 0, 8'h00, 0,   1,   0,   0,  0,  0,        0,        1, 8'h05, 16'h1234);
    add_row(0,  1, 0, 8'h05, 16'h0000, 0, 0, 8'h00, 0,   0,   0,   0,  0,  0,        0,        0, 8'h05, 16'h1234);
    add_row(0,  1, 0, 8'h05, 16'h0000, 0, 0, 8'h00, 0,   1,   0,   0,  0,  0,        0,        0, 8'h05, 16'h0000);
    add_row(0,  0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0,   0,   0,   1,  0,  16'h1234, 0,        0, 8'h05, 16'h0000);
    add_row(0,  0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0,   0,   0,   0,  0,  0,        0,        0, 8'h05, 16'h0000);
    add_row(1,  0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0,   0,   0,   0,  0,  0,        0,        0, 8'h00, 16'h0000);
    add_row(0,  0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 0,   0,   0,   0,  0,  0,        0,        0, 8'h00, 16'h0000);
    add_row(0,  0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 0,   0,   1,   0,  0,  0,        0,        0, 8'h20, 16'h0000);
    add_row(0,  0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0,   0,   0,   0,  1,  0,        16'h20DF, 0, 8'h20, 16'h0000);
    add_row(0,  1, 1, 8'h3A, 16'hBEEF, 1, 0, 8'h3A, 0,   0,   0,   0,  0,  0,        0,        0, 8'h20, 16'h0000);
    add_row(0,  1, 1, 8'h3A, 16'hBEEF, 1, 0, 8'h3A, 0,   1,   0,   0,  0,  0,        0,        1, 8'h3A, 16'hBEEF);
    add_row(0,  0, 0, 8'h00, 16'h0000, 1, 0, 8'h3A, 0,   0,   0,   0,  0,  0,        0,        0, 8'h3A, 16'hBEEF);
    add_row(0,  0, 0, 8'h00, 16'h0000, 1, 0, 8'h3A, 0,   0,   1,   0,  0,  0,        0,        0, 8'h3A, 16'h0000);
    add_row(0,  0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0,   0,   0,   0,  1,  0,        16'hBEEF, 0, 8'h3A, 16'h0000);
    add_row(0,  0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0,   0,   0,   0,  0,  0,        0,        0, 8'h3A, 16'h0000);

    foreach (vq[i]) begin
      step();
      reset = vq[i].rst;
      set_in(vq[i].r0, vq[i].w0, vq[i].a0, vq[i].d0, vq[i].r1, vq[i].w1, vq[i].a1, vq[i].d1);
      #1;
      s = $sformatf("vec%0d", i);
      chk({s, "_ack0"}, bus.ack0, vq[i].ack0);
      chk({s, "_ack1"}, bus.ack1, vq[i].ack1);
      chk({s, "_rvalid0"}, bus.rvalid0, vq[i].rv0);
      chk({s, "_rvalid1"}, bus.rvalid1, vq[i].rv1);
      chk({s, "_rdata0"}, bus.rdata0, vq[i].rd0);
      chk({s, "_rdata1"}, bus.rdata1, vq[i].rd1);
      chk({s, "_mem_write"}, bus.mem_write, vq[i].mw);
      chk({s, "_mem_wa"}, bus.mem_write_adress, vq[i].ma);
      chk({s, "_mem_ra"}, bus.mem_read_adress, vq[i].ma);
      chk({s, "_mem_din"}, bus.mem_din, vq[i].md);
    end
    reset = 1'b0;

    // ---------- contention: both ports read continuously, grants alternate ----------
    do_reset();
    for (int c = 0; c < 12; c++) begin
      int ph;
      int pt;
      logic [DW-1:0] ed;
      if (c > 0) step();
      set_in(1, 0, 8'h10, 0, 1, 0, 8'h20, 0);
      #1;
      ph = c % 3;
      pt = (c / 3) % 2;
      ed = (pt == 1) ? pat(8'h20) : pat(8'h10);
      s = $sformatf("rr_c%0d", c);
      chk({s, "_ack0"}, bus.ack0, (ph == 1 && pt == 0));
      chk({s, "_ack1"}, bus.ack1, (ph == 1 && pt == 1));
      chk({s, "_rvalid0"}, bus.rvalid0, (ph == 2 && pt == 0));
      chk({s, "_rvalid1"}, bus.rvalid1, (ph == 2 && pt == 1));
      chk({s, "_rdata0"}, bus.rdata0, (ph == 2 && pt == 0) ? ed : 16'h0000);
      chk({s, "_rdata1"}, bus.rdata1, (ph == 2 && pt == 1) ? ed : 16'h0000);
    end

    // ---------- reset during the WAIT cycle of a port-1 read ----------
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, 8'h20, 0);
    #1;
    step(); #1;
    chk("rstwait_ack1", bus.ack1, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step(); #1;
    chk("rstwait_pre_rvalid1", bus.rvalid1, 1);
    reset = 1'b1;
    #1;
    chk("rstwait_rvalid1", bus.rvalid1, 0);
    chk("rstwait_rdata1", bus.rdata1, 0);
    chk("rstwait_state", dbg_state, 0);
    chk("rstwait_prio", dbg_prio, 0);
    chk("rstwait_mem_ra", bus.mem_read_adress, 0);
    step(); #1;
    chk("rstwait_hold_rvalid1", bus.rvalid1, 0);
    reset = 1'b0;
    step(); #1;
    chk("rstwait_after_rvalid1", bus.rvalid1, 0);
    chk("rstwait_after_state", dbg_state, 0);
    set_in(1, 0, 8'h10, 0, 0, 0, 0, 0);
    #1;
    chk("rstwait_req_ack0_early", bus.ack0, 0);
    step(); #1;
    chk("rstwait_req_ack0", bus.ack0, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step(); #1;
    chk("rstwait_rvalid0", bus.rvalid0, 1);
    chk("rstwait_rdata0", bus.rdata0, pat(8'h10));
    chk("rstwait_no_rvalid1", bus.rvalid1, 0);

    // ---------- back-to-back port-0 writes ----------
    do_reset();
    for (int i = 0; i < 6; i++) wd[i] = 16'($urandom);
    wr_total = 0;
    for (int c = 0; c < 12; c++) begin
      int i;
      if (c > 0) step();
      i = c / 2;
      set_in(1, 1, 8'h80 + 8'(i), wd[i], 0, 0, 0, 0);
      #1;
      s = $sformatf("b2b_c%0d", c);
      chk({s, "_mem_write"}, bus.mem_write, (c % 2) == 1);
      if ((c % 2) == 1) begin
        chk({s, "_ack0"}, bus.ack0, 1);
        chk({s, "_mem_wa"}, bus.mem_write_adress, 8'h80 + 8'(i));
        chk({s, "_mem_din"}, bus.mem_din, wd[i]);
      end
      if (bus.mem_write) begin
        wcnt[bus.mem_write_adress]++;
        wr_total++;
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step(); #1;
    chk("b2b_tail_mem_write", bus.mem_write, 0);
    chk("b2b_total_writes", wr_total, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("b2b_wcnt%0d", i), wcnt[8'h80 + i], 1);
    for (int i = 0; i < 6; i++) begin
      step();
      set_in(0, 0, 0, 0, 1, 0, 8'h80 + 8'(i), 0);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      step(); #1;
      chk($sformatf("b2b_rd%0d_rvalid1", i), bus.rvalid1, 1);
      chk($sformatf("b2b_rd%0d_rdata1", i), bus.rdata1, wd[i]);
    end

    // ---------- randomized run against the transaction model ----------
    do_reset();
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; p_we[p] = 0; p_addr[p] = 0; p_data[p] = 0; last_ack[p] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      e_ack0[k] = 0; e_ack1[k] = 0; e_rv0[k] = 0; e_rv1[k] = 0; e_mw[k] = 0;
      e_wa[k] = 0; e_din[k] = 0;
    end
    next_dec = 0;
    m_prio   = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      int sl;
      if (cyc > 0) step();
      // requesters: finish on ack, optionally present a new command
      for (int p = 0; p < 2; p++) begin
        if (last_ack[p]) p_req[p] = 0;
        if (cyc < 290 && !p_req[p] && $urandom_range(0, 1) == 1) begin
          p_req[p]  = 1;
          p_we[p]   = 1'($urandom_range(0, 1));
          p_addr[p] = 8'h40 + 8'($urandom_range(0, 7));
          p_data[p] = 16'($urandom);
        end
      end
      set_in(p_req[0], p_we[0], p_addr[0], p_data[0], p_req[1], p_we[1], p_addr[1], p_data[1]);
      // model: serve one command at a time, round robin on contention
      if (cyc >= next_dec && (p_req[0] || p_req[1])) begin
        int w;
        w = (p_req[0] && p_req[1]) ? int'(m_prio) : (p_req[1] ? 1 : 0);
        m_prio = (w == 0);
        if (w == 0) e_ack0[(cyc + 1) % 8] = 1; else e_ack1[(cyc + 1) % 8] = 1;
        if (p_we[w]) begin
          e_mw[(cyc + 1) % 8]  = 1;
          e_wa[(cyc + 1) % 8]  = p_addr[w];
          e_din[(cyc + 1) % 8] = p_data[w];
          shadow[p_addr[w]]    = p_data[w];
          next_dec = cyc + 2;
        end else begin
          if (w == 0) begin
            e_rv0[(cyc + 2) % 8] = 1;
            exp_q0.push_back(shadow[p_addr[w]]);
          end else begin
            e_rv1[(cyc + 2) % 8] = 1;
            exp_q1.push_back(shadow[p_addr[w]]);
          end
          next_dec = cyc + 3;
        end
      end
      #1;
      sl = cyc % 8;
      s = $sformatf("rand_c%0d", cyc);
      chk({s, "_ack0"}, bus.ack0, e_ack0[sl]);
      chk({s, "_ack1"}, bus.ack1, e_ack1[sl]);
      chk({s, "_rvalid0"}, bus.rvalid0, e_rv0[sl]);
      chk({s, "_rvalid1"}, bus.rvalid1, e_rv1[sl]);
      chk({s, "_mem_write"}, bus.mem_write, e_mw[sl]);
      if (e_mw[sl]) begin
        chk({s, "_mem_wa"}, bus.mem_write_adress, e_wa[sl]);
        chk({s, "_mem_din"}, bus.mem_din, e_din[sl]);
      end
      if (bus.rvalid0) begin
        if (exp_q0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL %s_rdata0: got rvalid0 with %h, required no read pending", s, bus.rdata0);
        end else chk({s, "_rdata0"}, bus.rdata0, exp_q0.pop_front());
      end else chk({s, "_rdata0_idle"}, bus.rdata0, 0);
      if (bus.rvalid1) begin
        if (exp_q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL %s_rdata1: got rvalid1 with %h, required no read pending", s, bus.rdata1);
        end else chk({s, "_rdata1"}, bus.rdata1, exp_q1.pop_front());
      end else chk({s, "_rdata1_idle"}, bus.rdata1, 0);
      e_ack0[sl] = 0; e_ack1[sl] = 0; e_rv0[sl] = 0; e_rv1[sl] = 0; e_mw[sl] = 0;
      last_ack[0] = bus.ack0;
      last_ack[1] = bus.ack1;
    end
    chk("rand_drain_q0", exp_q0.size(), 0);
    chk("rand_drain_q1", exp_q1.size(), 0);

    // ---------- report ----------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
